// File: rtl/alu_arbiter.sv
`default_nettype none
//============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin front end for a 16-bit combinational
//            ALU. Grants one operation at a time and holds the winner's
//            operands on the ALU inputs. The ALU result is registered and
//            returned, tagged with the requester ID, over a valid/ready
//            response channel. Completions are counted per requester.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req_valid/req_ready    - per-requester request handshake
//            req_a*/req_b*/req_cin/req_opc* - per-requester operation
//            alu_a/alu_b/alu_cin/alu_opc    - to external ALU
//            alu_w/alu_zer/alu_neg          - from external ALU
//            resp_valid/resp_ready/resp_*   - response channel
//            done_cnt0/done_cnt1    - wrapping completion counters
// Revision : 1.0 - initial release
//============================================================================
module alu_arbiter #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [W-1:0]  req_a0,
    input  logic [W-1:0]  req_b0,
    input  logic [W-1:0]  req_a1,
    input  logic [W-1:0]  req_b1,
    input  logic [1:0]    req_cin,
    input  logic [2:0]    req_opc0,
    input  logic [2:0]    req_opc1,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_cin,
    output logic [2:0]    alu_opc,
    input  logic [W-1:0]  alu_w,
    input  logic          alu_zer,
    input  logic          alu_neg,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_data,
    output logic          resp_zer,
    output logic          resp_neg,
    output logic          resp_id,
    output logic [CW-1:0] done_cnt0,
    output logic [CW-1:0] done_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic          r_lastGrant;
    logic          r_id;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_cin;
    logic [2:0]    r_opc;
    logic [W-1:0]  r_data;
    logic          r_zer;
    logic          r_neg;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic          w_grant;
    logic          w_grantId;
    logic          w_respFire;

    // Winner selection: a lone requester always wins; on a tie the
    // requester that was not granted last takes its turn.
    always_comb begin
        w_grantId = 1'b0;
        case (req_valid)
            2'b01:   w_grantId = 1'b0;
            2'b10:   w_grantId = 1'b1;
            2'b11:   w_grantId = ~r_lastGrant;
            default: w_grantId = 1'b0;
        endcase
    end

    // rst_n is folded in so req_ready stays low for the whole time reset
    // is held, even while requesters keep their valid bits asserted.
    assign w_grant    = (r_state == S_IDLE) && (|req_valid) && rst_n;
    assign w_respFire = (r_state == S_RESP) && resp_ready;

    assign req_ready  = w_grant ? (w_grantId ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (|req_valid) w_nextState = S_EXEC;
            S_EXEC:  w_nextState = S_RESP;
            S_RESP:  if (resp_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand registers: loaded only on a grant, so the ALU inputs stay
    // stable through EXEC and RESP until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= 1'b1;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_opc       <= 3'd0;
        end else if (w_grant) begin
            r_lastGrant <= w_grantId;
            r_id        <= w_grantId;
            r_a         <= w_grantId ? req_a1   : req_a0;
            r_b         <= w_grantId ? req_b1   : req_b0;
            r_cin       <= req_cin[w_grantId];
            r_opc       <= w_grantId ? req_opc1 : req_opc0;
        end
    end

    // Result capture at the end of the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_zer  <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_data <= alu_w;
            r_zer  <= alu_zer;
            r_neg  <= alu_neg;
        end
    end

    // Completion counters wrap naturally at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_respFire) begin
            if (r_id) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_cin    = r_cin;
    assign alu_opc    = r_opc;

    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_data;
    assign resp_zer   = r_zer;
    assign resp_neg   = r_neg;
    assign resp_id    = r_id;

    assign done_cnt0  = r_cnt0;
    assign done_cnt1  = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with an adder stub ALU.
//            Directed vector table, hand-written corner sequences, and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_cin;
    logic [2:0]  req_opc0, req_opc1;
    logic [15:0] alu_a, alu_b, alu_w;
    logic        alu_cin, alu_zer, alu_neg;
    logic [2:0]  alu_opc;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic        resp_zer, resp_neg, resp_id;
    logic [7:0]  done_cnt0, done_cnt1;

    int passCnt  = 0;
    int totalCnt = 0;

    alu_arbiter #(.W(16), .CW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_cin    (req_cin),
        .req_opc0   (req_opc0),
        .req_opc1   (req_opc1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_opc    (alu_opc),
        .alu_w      (alu_w),
        .alu_zer    (alu_zer),
        .alu_neg    (alu_neg),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zer   (resp_zer),
        .resp_neg   (resp_neg),
        .resp_id    (resp_id),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    // Stub ALU: add with carry.
    assign alu_w   = alu_a + alu_b + {15'd0, alu_cin};
    assign alu_zer = (alu_w == 16'd0);
    assign alu_neg = alu_w[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passCnt++;
        end
    endtask

    task automatic driveOp(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [2:0] opc);
        if (id == 0) begin
            req_a0 = a; req_b0 = b; req_cin[0] = cin; req_opc0 = opc;
        end else begin
            req_a1 = a; req_b1 = b; req_cin[1] = cin; req_opc1 = opc;
        end
    endtask

    // Called at a negedge with the block idle; leaves at a negedge with the
    // block idle again after a three-cycle operation.
    task automatic runOp(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] opc,
                         input logic [15:0] ed, input logic ez, input logic en);
        driveOp(id, a, b, cin, opc);
        req_valid      = 2'b00;
        req_valid[id]  = 1'b1;
        resp_ready     = 1'b1;
        #1;
        check("op_grant", 32'(req_ready), (id == 0) ? 32'd1 : 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("op_exec_valid", 32'(resp_valid), 32'd0);
        check("op_alu_opc", 32'(alu_opc), 32'(opc));
        @(negedge clk);
        #1;
        check("op_resp_valid", 32'(resp_valid), 32'd1);
        check("op_resp_data", 32'(resp_data), 32'(ed));
        check("op_resp_zer", 32'(resp_zer), 32'(ez));
        check("op_resp_neg", 32'(resp_neg), 32'(en));
        check("op_resp_id", 32'(resp_id), 32'(id));
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  opc;
        logic [15:0] ed;
        logic        ez;
        logic        en;
    } vec_t;

    vec_t vecs[6];

    // Reference model state for the random run.
    typedef struct {
        logic        id;
        logic [15:0] d;
    } exp_t;
    exp_t        q[$];

    initial begin
        logic [15:0] heldData;
        logic [1:0]  pend;
        logic [1:0]  prevGrant;
        logic [15:0] ra[2];
        logic [15:0] rb[2];
        logic        rc[2];
        logic [2:0]  ro[2];
        int          age;
        int          lastWin;
        int          winner;
        int          mc[2];
        logic [1:0]  expReady;
        logic [16:0] sum;
        exp_t        e;

        req_valid = 2'b00; req_cin = 2'b00;
        req_a0 = 16'd0; req_b0 = 16'd0; req_a1 = 16'd0; req_b1 = 16'd0;
        req_opc0 = 3'd0; req_opc1 = 3'd0;
        resp_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state, with both requesters pushing during reset.
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_cnt0", 32'(done_cnt0), 32'd0);
        check("rst_cnt1", 32'(done_cnt1), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        vecs[0] = '{0, 16'h0003, 16'h0005, 1'b1, 3'b010, 16'h0009, 1'b0, 1'b0};
        vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 3'b001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{0, 16'h7FFF, 16'h0001, 1'b0, 3'b111, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1, 16'h1234, 16'h4321, 1'b1, 3'b100, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 3'b011, 16'hFFFF, 1'b0, 1'b1};
        vecs[5] = '{1, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            runOp(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].opc,
                  vecs[i].ed, vecs[i].ez, vecs[i].en);
            if (i == 0) check("single_cnt0", 32'(done_cnt0), 32'd1);
        end
        check("table_cnt0", 32'(done_cnt0), 32'd3);
        check("table_cnt1", 32'(done_cnt1), 32'd3);

        // Tie after reset: both held valid, grants alternate 0,1,0,1,0,1.
        doReset();
        driveOp(0, 16'hFFFF, 16'h0001, 1'b0, 3'd0);
        driveOp(1, 16'h7FFF, 16'h0001, 1'b0, 3'd0);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("tie_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            @(negedge clk);
            #1;
            check("tie_resp_id", 32'(resp_id), 32'(k % 2));
            check("tie_resp_data", 32'(resp_data), (k % 2 == 0) ? 32'h0000 : 32'h8000);
            check("tie_resp_flags", {30'd0, resp_zer, resp_neg}, (k % 2 == 0) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        check("tie_cnt0", 32'(done_cnt0), 32'd3);
        check("tie_cnt1", 32'(done_cnt1), 32'd3);

        // Backpressure: response stalled for 10 cycles while requester 1 waits.
        driveOp(0, 16'h0100, 16'h0023, 1'b1, 3'd5);
        driveOp(1, 16'h0002, 16'h0002, 1'b0, 3'd6);
        req_valid  = 2'b01;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_valid = 2'b10;
        heldData  = 16'h0124;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data", 32'(resp_data), 32'(heldData));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_fire_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        #1;
        check("bp_next_grant", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("bp_next_data", 32'(resp_data), 32'h0004);
        check("bp_next_id", 32'(resp_id), 32'd1);
        @(negedge clk);

        // Counter wrap: 256 operations from requester 1.
        doReset();
        for (int n = 0; n < 256; n++) begin
            runOp(1, 16'(n), 16'h0001, 1'b0, 3'd0, 16'(n + 1), 1'b0, 1'b0);
            if (n == 254) check("wrap_cnt1_255", 32'(done_cnt1), 32'd255);
        end
        check("wrap_cnt1", 32'(done_cnt1), 32'd0);
        check("wrap_cnt0", 32'(done_cnt0), 32'd0);

        // Reset mid-operation during EXEC.
        runOp(0, 16'h0001, 16'h0001, 1'b0, 3'd0, 16'h0002, 1'b0, 1'b0);
        driveOp(0, 16'h00AA, 16'h0055, 1'b0, 3'd1);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_alu_a", 32'(alu_a), 32'd0);
        check("mid_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_req_ready", 32'(req_ready), 32'd0);
        check("mid_resp_data", 32'(resp_data), 32'd0);
        check("mid_cnt0", 32'(done_cnt0), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("mid_no_resp", 32'(resp_valid), 32'd0);
        end
        check("mid_cnt_after", {done_cnt1, done_cnt0}, 32'd0);
        @(negedge clk);
        runOp(0, 16'h1000, 16'h0FFF, 1'b1, 3'd2, 16'h2000, 1'b0, 1'b0);

        // Randomized run against the transaction model.
        doReset();
        pend = 2'b00; prevGrant = 2'b00; age = 0; lastWin = 1;
        mc[0] = 0; mc[1] = 0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = 16'd0; rb[i] = 16'd0; rc[i] = 1'b0; ro[i] = 3'd0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (prevGrant[i]) pend[i] = 1'b0;
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    ra[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    rb[i] = 16'($urandom);
                    rc[i] = 1'($urandom);
                    ro[i] = 3'($urandom);
                end
                driveOp(i, ra[i], rb[i], rc[i], ro[i]);
            end
            req_valid  = pend;
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (q.size() > 0) age++;

            check("rnd_cnt0", 32'(done_cnt0), 32'(mc[0] % 256));
            check("rnd_cnt1", 32'(done_cnt1), 32'(mc[1] % 256));

            expReady = 2'b00;
            winner   = 0;
            if (q.size() == 0 && pend != 2'b00) begin
                if (pend == 2'b01)      winner = 0;
                else if (pend == 2'b10) winner = 1;
                else                    winner = 1 - lastWin;
                expReady[winner] = 1'b1;
            end
            check("rnd_req_ready", 32'(req_ready), 32'(expReady));
            check("rnd_resp_valid", 32'(resp_valid), (q.size() > 0 && age >= 2) ? 32'd1 : 32'd0);

            if (q.size() > 0 && age >= 2) begin
                check("rnd_resp_data", 32'(resp_data), 32'(q[0].d));
                check("rnd_resp_id", 32'(resp_id), 32'(q[0].id));
                check("rnd_resp_flags", {30'd0, resp_zer, resp_neg},
                      {30'd0, (q[0].d == 16'd0), q[0].d[15]});
                if (resp_ready) begin
                    mc[q[0].id] = mc[q[0].id] + 1;
                    void'(q.pop_front());
                end
            end

            if (expReady != 2'b00) begin
                sum  = {1'b0, ra[winner]} + {1'b0, rb[winner]} + {16'd0, rc[winner]};
                e.id = winner[0];
                e.d  = sum[15:0];
                q.push_back(e);
                age     = 0;
                lastWin = winner;
            end
            prevGrant = req_ready;
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
